// File: rtl/sprite_pixel_server_pkg.sv
// Shared constants and load-FSM encoding for the sprite pixel server.
// Coordinates are 7 bits each; a pixel address is {y, x}.
package sprite_pixel_server_pkg;
   localparam int          SPR_W_DEF       = 84;
   localparam int          SPR_H_DEF       = 70;
   localparam logic [11:0] TRANSPARENT_DEF = 12'hfff;
   localparam int          COORD_W         = 7;
   localparam int          ADDR_W          = 2 * COORD_W;
   localparam int          RGB_W           = 12;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PEND    = 3'd1,
      LOAD_HI = 3'd2,
      LOAD_LO = 3'd3,
      DONE    = 3'd4
   } load_state_t;
endpackage

// File: rtl/sprite_pixel_server_ram.sv
// Sprite image store: one write port, one synchronous read port, read-first.
module sprite_ram
  import sprite_pixel_server_pkg::*;
#(
  parameter string MEMFILE = ""
) (
  input  logic              pclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [RGB_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [RGB_W-1:0]  rdata
);
  logic [RGB_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // Non-blocking read alongside the write gives old data on a same-address collision.
  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sprite_pixel_server.sv
// Sprite pixel responder: 1-cycle read of the sprite RAM with out-of-sprite masking,
// plus a vblank-gated reload FSM that writes 2 stream bytes per pixel in raster order.
module sprite_pixel_server
   import sprite_pixel_server_pkg::*;
#(
   parameter int          SPR_W       = SPR_W_DEF,
   parameter int          SPR_H       = SPR_H_DEF,
   parameter logic [11:0] TRANSPARENT = TRANSPARENT_DEF,
   parameter string       MEMFILE     = ""
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [13:0] pixel_addr,
   output logic [11:0] rgb_pixel,
   input  logic        vblnk_in,
   input  logic        load_start,
   input  logic [7:0]  load_data,
   input  logic        load_valid,
   output logic        load_ready,
   output logic        load_busy,
   output logic        load_done
);
   // Stream handshake: a byte transfers on a rising edge where load_valid and
   // load_ready are both high; load_ready depends only on FSM state.
   load_state_t state, state_nxt;
   logic [COORD_W-1:0] wx, wy, wx_nxt, wy_nxt;
   logic [3:0]         r_q, r_nxt;
   logic               we;
   logic               last_pix;
   logic               hide_q;
   logic [RGB_W-1:0]   ram_q;
   logic [COORD_W-1:0] rd_x, rd_y;

   assign rd_x     = pixel_addr[COORD_W-1:0];
   assign rd_y     = pixel_addr[ADDR_W-1:COORD_W];
   assign last_pix = ({1'b0, wx} == 8'(SPR_W - 1)) && ({1'b0, wy} == 8'(SPR_H - 1));

   always_comb begin
      state_nxt  = state;
      wx_nxt     = wx;
      wy_nxt     = wy;
      r_nxt      = r_q;
      we         = 1'b0;
      load_ready = 1'b0;
      load_busy  = 1'b0;
      load_done  = 1'b0;
      case (state)
         IDLE: if (load_start) state_nxt = PEND;
         PEND: begin
            load_busy = 1'b1;
            if (vblnk_in) begin
               state_nxt = LOAD_HI;
               wx_nxt    = '0;
               wy_nxt    = '0;
            end
         end
         LOAD_HI: begin
            load_busy  = 1'b1;
            load_ready = 1'b1;
            if (load_valid) begin
               r_nxt     = load_data[3:0];
               state_nxt = LOAD_LO;
            end
         end
         LOAD_LO: begin
            load_busy  = 1'b1;
            load_ready = 1'b1;
            if (load_valid) begin
               we = 1'b1;
               if (last_pix) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = LOAD_HI;
                  if ({1'b0, wx} == 8'(SPR_W - 1)) begin
                     wx_nxt = '0;
                     wy_nxt = wy + 7'd1;
                  end else begin
                     wx_nxt = wx + 7'd1;
                  end
               end
            end
         end
         DONE: begin
            load_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // hide_q is sampled with the address so the mask lines up with the RAM output.
   always_ff @(posedge pclk) begin
      if (!rst) begin
         state  <= IDLE;
         wx     <= '0;
         wy     <= '0;
         r_q    <= '0;
         hide_q <= 1'b1;
      end else begin
         state  <= state_nxt;
         wx     <= wx_nxt;
         wy     <= wy_nxt;
         r_q    <= r_nxt;
         hide_q <= ({1'b0, rd_x} >= 8'(SPR_W)) || ({1'b0, rd_y} >= 8'(SPR_H)) ||
                   (state == LOAD_HI) || (state == LOAD_LO);
      end
   end

   sprite_ram #(.MEMFILE(MEMFILE)) u_ram (
      .pclk  (pclk),
      .we    (we),
      .waddr ({wy, wx}),
      .wdata ({r_q, load_data}),
      .raddr (pixel_addr),
      .rdata (ram_q)
   );

   assign rgb_pixel = hide_q ? TRANSPARENT : ram_q;
endmodule

// File: tb/tb_sprite_pixel_server.sv
// Bench for sprite_pixel_server: directed reads, vblank-gated reload, full raster
// reload with readback, and reset during a second reload.
module tb_sprite_pixel_server;
   logic        pclk = 1'b0;
   logic        rst = 1'b0;
   logic [13:0] pixel_addr = '0;
   logic [11:0] rgb_pixel;
   logic        vblnk_in = 1'b0;
   logic        load_start = 1'b0;
   logic [7:0]  load_data = '0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic        load_busy;
   logic        load_done;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   logic [11:0] exp_q[$];
   logic        rd_req = 1'b0;
   logic        rd_armed = 1'b0;

   localparam int W = 84;
   localparam int H = 70;

   // clock / reset
   always #5 pclk = ~pclk;

   sprite_pixel_server dut (
      .pclk       (pclk),
      .rst        (rst),
      .pixel_addr (pixel_addr),
      .rgb_pixel  (rgb_pixel),
      .vblnk_in   (vblnk_in),
      .load_start (load_start),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_busy  (load_busy),
      .load_done  (load_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: a read issued before edge N is compared just after edge N
   always @(posedge pclk) rd_armed <= rd_req;

   always @(negedge pclk) begin
      if (rd_armed) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_scoreboard: output with no expected entry, got %0h", rgb_pixel);
         end else begin
            check("rgb_pixel", {20'd0, rgb_pixel}, {20'd0, exp_q.pop_front()});
         end
      end
      if (load_done) begin
         done_cnt++;
         check("busy_at_done", {31'd0, load_busy}, 32'd0);
      end
   end

   // driver tasks
   task automatic step();
      @(negedge pclk);
      rd_req = 1'b0;
   endtask

   task automatic issue_read(input int y, input int x, input logic [11:0] e);
      pixel_addr = {7'(y), 7'(x)};
      exp_q.push_back(e);
      rd_req = 1'b1;
   endtask

   task automatic send_stream(input int n_bytes, input logic [7:0] hi, input bit inv, input bit poke);
      int gaps;
      int budget;
      logic [7:0] kb;
      for (int j = 0; j < n_bytes; j++) begin
         kb = 8'(j / 2);
         load_valid = 1'b0;
         gaps = $urandom_range(0, 2);
         repeat (gaps) step();
         load_data  = (j % 2 == 0) ? hi : (inv ? ~kb : kb);
         load_valid = 1'b1;
         if (poke && j == 500) load_start = 1'b1;
         if (j % 1500 == 3) issue_read(j % H, j % W, 12'hfff);
         budget = 0;
         while (!load_ready && budget < 20) begin
            step();
            budget++;
         end
         if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL stream_ready_timeout: byte %0d never accepted", j);
            load_valid = 1'b0;
            load_start = 1'b0;
            return;
         end
         step();
         load_start = 1'b0;
      end
      load_valid = 1'b0;
   endtask

   // stimulus
   initial begin
      repeat (3) step();
      check("reset_rgb", {20'd0, rgb_pixel}, 32'hfff);
      check("reset_ready", {31'd0, load_ready}, 32'd0);
      check("reset_busy", {31'd0, load_busy}, 32'd0);
      check("reset_done", {31'd0, load_done}, 32'd0);
      rst = 1'b1;
      step();

      issue_read(0, 84, 12'hfff);
      step();
      issue_read(70, 0, 12'hfff);
      step();
      issue_read(127, 127, 12'hfff);
      step();
      step();

      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         check("pend_busy", {31'd0, load_busy}, 32'd1);
         check("pend_ready", {31'd0, load_ready}, 32'd0);
      end
      vblnk_in = 1'b1;
      step();
      check("ready_after_vblank", {31'd0, load_ready}, 32'd1);
      vblnk_in = 1'b0;

      send_stream(2 * W * H, 8'h0A, 1'b0, 1'b1);
      repeat (6) step();
      check("done_count", done_cnt, 32'd1);
      check("idle_busy", {31'd0, load_busy}, 32'd0);
      check("idle_ready", {31'd0, load_ready}, 32'd0);

      for (int k = 0; k < W * H; k++) begin
         step();
         issue_read(k / W, k % W, {4'hA, 8'(k)});
      end
      step();
      issue_read(0, 84, 12'hfff);
      step();
      issue_read(70, 83, 12'hfff);
      step();
      issue_read(69, 83, {4'hA, 8'(69 * W + 83)});
      repeat (3) step();

      vblnk_in   = 1'b1;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      send_stream(100, 8'h05, 1'b1, 1'b0);
      rst = 1'b0;
      step();
      check("midreset_ready", {31'd0, load_ready}, 32'd0);
      check("midreset_busy", {31'd0, load_busy}, 32'd0);
      check("midreset_rgb", {20'd0, rgb_pixel}, 32'hfff);
      rst      = 1'b1;
      vblnk_in = 1'b0;
      step();
      for (int k = 0; k < 52; k++) begin
         step();
         if (k < 50) issue_read(0, k, {4'h5, ~8'(k)});
         else        issue_read(0, k, {4'hA, 8'(k)});
      end
      repeat (4) step();
      check("queue_drained", exp_q.size(), 32'd0);
      check("final_done_count", done_cnt, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
